// File: rtl/mgr_desc_arb_pkg.sv
// rtl/mgr_desc_arb_pkg.sv - shared manager types: descriptor delineators and arbiter states
package mgr_desc_arb_pkg;

   typedef enum logic [1:0] {
      CNTL_MOD     = 2'b00,
      CNTL_SOD     = 2'b01,
      CNTL_EOD     = 2'b10,
      CNTL_SOD_EOD = 2'b11
   } cntl_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic logic is_start(input logic [1:0] cntl);
      return (cntl == CNTL_SOD) || (cntl == CNTL_SOD_EOD);
   endfunction

   function automatic logic is_end(input logic [1:0] cntl);
      return (cntl == CNTL_EOD) || (cntl == CNTL_SOD_EOD);
   endfunction

endpackage

// File: rtl/mgr_desc_fifo.sv
// rtl/mgr_desc_fifo.sv - per-channel descriptor beat FIFO with registered occupancy
module mgr_desc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_poweron,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             avail
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   // The entry written on the previous edge is held back one cycle from arbitration.
   assign avail   = (count > {{AW{1'b0}}, push_q});
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && avail;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         push_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         push_q <= do_push;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mgr_desc_arb.sv
// rtl/mgr_desc_arb.sv - round-robin merge of per-channel descriptor streams with optional descriptor lock
module mgr_desc_arb
   import mgr_desc_arb_pkg::*;
#(
   parameter int NUM_CHAN     = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int OPT_PER_INST = 3,
   parameter int OPT_TYPE_W   = 8,
   parameter int OPT_VALUE_W  = 24,
   parameter int LOCK_MODE    = 1
) (
   input  logic                                      clk,
   input  logic                                      reset_poweron,
   input  logic [NUM_CHAN-1:0]                       in_valid,
   output logic [NUM_CHAN-1:0]                       in_ready,
   input  logic [2*NUM_CHAN-1:0]                     in_cntl,
   input  logic [NUM_CHAN*OPT_PER_INST*OPT_TYPE_W-1:0]  in_option_type,
   input  logic [NUM_CHAN*OPT_PER_INST*OPT_VALUE_W-1:0] in_option_value,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [1:0]                                out_cntl,
   output logic [OPT_PER_INST*OPT_TYPE_W-1:0]        out_option_type,
   output logic [OPT_PER_INST*OPT_VALUE_W-1:0]       out_option_value,
   output logic [$clog2(NUM_CHAN)-1:0]               out_chan_id,
   output logic [NUM_CHAN-1:0]                       err_seq
);

   localparam int CW = $clog2(NUM_CHAN);
   localparam int TW = OPT_PER_INST * OPT_TYPE_W;
   localparam int VW = OPT_PER_INST * OPT_VALUE_W;
   localparam int DW = 2 + TW + VW;

   logic [NUM_CHAN-1:0][DW-1:0] head;
   logic [NUM_CHAN-1:0]         full;
   logic [NUM_CHAN-1:0]         avail;
   logic [NUM_CHAN-1:0]         pop;
   logic [NUM_CHAN-1:0]         push;
   logic [NUM_CHAN-1:0]         elig;
   logic [NUM_CHAN-1:0]         in_desc;
   logic [DW-1:0]               sel;
   logic [1:0]                  sel_cntl;
   arb_state_t                  state_q, state_d;
   logic [CW-1:0]               lock_q, lock_d;
   logic [CW-1:0]               rr_q, rr_d;
   logic [CW-1:0]               gnt;
   logic [CW-1:0]               idx_c;
   logic                        found;
   logic                        load;
   int                          idx;

   assign in_ready = ~full;
   assign push     = in_valid & ~full;

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      mgr_desc_fifo #(
         .WIDTH (DW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk           (clk),
         .reset_poweron (reset_poweron),
         .push          (in_valid[c]),
         .wdata         ({in_cntl[2*c +: 2], in_option_type[c*TW +: TW], in_option_value[c*VW +: VW]}),
         .pop           (pop[c]),
         .rdata         (head[c]),
         .full          (full[c]),
         .avail         (avail[c])
      );
   end

   // Sequence errors are flagged but never block or drop the beat.
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         in_desc <= '0;
         err_seq <= '0;
      end else begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            if (push[c]) begin
               if (in_desc[c] ? is_start(in_cntl[2*c +: 2]) : !is_start(in_cntl[2*c +: 2]))
                  err_seq[c] <= 1'b1;
               in_desc[c] <= (in_desc[c] || is_start(in_cntl[2*c +: 2])) && !is_end(in_cntl[2*c +: 2]);
            end
         end
      end
   end

   always_comb begin
      elig = '0;
      for (int c = 0; c < NUM_CHAN; c++)
         elig[c] = avail[c] && ((LOCK_MODE == 0) || (state_q == ST_IDLE) || (lock_q == CW'(c)));

      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      idx_c = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
         idx_c = CW'(idx);
         if (!found && elig[idx_c]) begin
            found = 1'b1;
            gnt   = idx_c;
         end
      end

      load = found && (!out_valid || out_ready);
      pop  = '0;
      if (load) pop[gnt] = 1'b1;
      sel      = head[gnt];
      sel_cntl = sel[DW-1 -: 2];

      state_d = state_q;
      lock_d  = lock_q;
      rr_d    = rr_q;
      if (load) begin
         if (LOCK_MODE != 0) begin
            case (state_q)
               ST_IDLE: begin
                  if (sel_cntl == CNTL_SOD) begin
                     state_d = ST_LOCKED;
                     lock_d  = gnt;
                  end
               end
               ST_LOCKED: begin
                  if (is_end(sel_cntl)) state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
         // The pointer only moves once a descriptor (or lone beat) has fully left.
         if ((LOCK_MODE == 0) || (state_d == ST_IDLE))
            rr_d = (gnt == CW'(NUM_CHAN-1)) ? '0 : gnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         rr_q    <= rr_d;
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         out_valid        <= 1'b0;
         out_cntl         <= '0;
         out_option_type  <= '0;
         out_option_value <= '0;
         out_chan_id      <= '0;
      end else if (load) begin
         out_valid                                     <= 1'b1;
         {out_cntl, out_option_type, out_option_value} <= sel;
         out_chan_id                                   <= gnt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/mgr_desc_arb.md
MGR_DESC_ARB -- requirements
Module: mgr_desc_arb

Interface
REQ-001 Parameter NUM_CHAN, default 4: number of descriptor input channels (2-8).
REQ-002 Parameter FIFO_DEPTH, default 4: per-channel FIFO entries (power of 2, at least 2).
REQ-003 Parameter OPT_PER_INST, default 3: option type/value pairs per beat.
REQ-004 Parameter OPT_TYPE_W, default 8, and OPT_VALUE_W, default 24: field widths.
REQ-005 Parameter LOCK_MODE, default 1: 1 = descriptor-atomic arbitration; 0 = per-beat round-robin.
REQ-006 Port clk, in, 1: the single clock; all logic on its rising edge.
REQ-007 Port reset_poweron, in, 1: reset, asynchronous and active-low.
REQ-008 Port in_valid, in, NUM_CHAN: per-channel beat valid.
REQ-009 Port in_ready, out, NUM_CHAN: per-channel FIFO can accept.
REQ-010 Port in_cntl, in, 2*NUM_CHAN: per-channel delineator (SOD/MOD/EOD/SOD_EOD).
REQ-011 Port in_option_type, in, NUM_CHAN*OPT_PER_INST*OPT_TYPE_W: option types.
REQ-012 Port in_option_value, in, NUM_CHAN*OPT_PER_INST*OPT_VALUE_W: option values.
REQ-013 Ports out_valid (out, 1), out_ready (in, 1), out_cntl (out, 2), out_option_type (out, OPT_PER_INST*OPT_TYPE_W) and out_option_value (out, OPT_PER_INST*OPT_VALUE_W): merged descriptor stream.
REQ-014 Port out_chan_id, out, clog2(NUM_CHAN): source channel of the current out beat.
REQ-015 Port err_seq, out, NUM_CHAN: sticky per-channel delineator-sequence error.

Function
REQ-016 A beat transfers on an input or output when valid and ready are both high on a rising edge; valid is never qualified by ready.
REQ-017 in_ready[c] shall be high when FIFO c holds fewer than FIFO_DEPTH entries, taken from a registered count; a full FIFO never accepts, even if popped in the same cycle.
REQ-018 A simultaneous push and pop on a non-full FIFO shall leave its count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-019 The output register shall load when out_valid is low or out_ready is high, and a granted FIFO head exists; otherwise it holds all out_* values.
REQ-020 Minimum latency: a beat accepted at edge N appears with out_valid high after edge N+2.
REQ-021 Arbitration shall be round-robin among non-empty FIFOs, starting from the channel after the last granted; the pointer is 0 after reset.
REQ-022 LOCK_MODE=1: the FSM has states IDLE and LOCKED; granting an SOD beat moves IDLE to LOCKED(ch).
REQ-023 LOCK_MODE=1, LOCKED(ch): only channel ch is eligible; popping its EOD beat returns the FSM to IDLE and advances the pointer; an SOD_EOD beat stays in IDLE.
REQ-024 LOCK_MODE=1, LOCKED(ch) with FIFO ch empty: no output load occurs and other channels wait (no bubble-filling).
REQ-025 LOCK_MODE=0: every beat is arbitrated independently and no FSM lock applies.
REQ-026 Per-channel input tracker: err_seq[c] shall set when MOD or EOD arrives outside a descriptor, or SOD/SOD_EOD arrives inside one; the beat is still accepted and forwarded.
REQ-027 err_seq bits shall clear only on reset.
REQ-028 out_chan_id shall be registered together with the output beat.

Reset
REQ-029 While reset_poweron is low, asynchronously: all FIFOs empty, in_ready all 1, out_valid 0, out_cntl 0, out_option_* 0, out_chan_id 0, err_seq 0, FSM IDLE, RR pointer 0.
REQ-030 Reset asserted mid-descriptor shall discard all in-flight beats; no partial descriptor is emitted after reset release.

Structure
REQ-031 Cntl encodings (MOD=00, SOD=01, EOD=10, SOD_EOD=11) and the FSM state enum shall live in the shared manager package, not locally.
REQ-032 One sub-module, mgr_desc_fifo (parametrised width and depth), shall be instantiated NUM_CHAN times.

Verification
REQ-033 Ch0 sends SOD,MOD,EOD and ch1 sends SOD,EOD concurrently, LOCK_MODE=1 -> out_chan_id is 0,0,0,1,1 with no interleaving.
REQ-034 Same stimulus with LOCK_MODE=0 -> out_chan_id is 0,1,0,1,0.
REQ-035 out_ready held 0 while ch2 pushes 5 beats, FIFO_DEPTH=4 -> in_ready[2] low after 4 accepted (5th blocked), output holds the first beat stable.
REQ-036 Ch3 sends MOD with no prior SOD -> err_seq=4'b1000 and the beat is still output; err_seq stays set until reset.
REQ-037 Reset asserted after an SOD is output but before its EOD -> out_valid 0 immediately, FSM IDLE; a post-reset SOD_EOD on ch1 emerges 2 cycles after acceptance.
REQ-038 All 4 channels continuously send SOD_EOD with out_ready=1 -> out_chan_id cycles 0,1,2,3,0 with one beat per cycle throughput.
